// File: rtl/test_scheduler.sv
// Batch test scheduler: queues test-parameter words, then issues them one at a time to a
// control block, collecting pass/fail results, with abort and per-test timeout handling.
module test_scheduler #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int IW         = $clog2(DEPTH)
) (
    input  logic          rst_i,
    input  logic          clk_i,
    input  logic          push_valid_i,
    input  logic [31:0]   push_param_i,
    output logic          push_ready_o,
    input  logic          clear_i,
    input  logic          run_i,
    input  logic          abort_i,
    output logic          test_start_o,
    output logic [31:0]   test_param_o,
    input  logic          test_finished_i,
    input  logic          test_result_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [IW-1:0] test_idx_o,
    output logic [7:0]    pass_cnt_o,
    output logic [7:0]    fail_cnt_o,
    output logic [DEPTH-1:0] fail_mask_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_RECORD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       param_q, param_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic              abort_q, abort_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        pass_q, pass_d, fail_q, fail_d;
    logic [DEPTH-1:0]  mask_q, mask_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              push_en_s;
    logic [AW-1:0]     rd_next_s;

    assign push_ready_o = (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign push_en_s    = push_valid_i && push_ready_o;
    assign rd_next_s    = rd_ptr_q + AW'(1);

    assign test_start_o = start_q;
    assign test_param_o = param_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign test_idx_o   = idx_q;
    assign pass_cnt_o   = pass_q;
    assign fail_cnt_o   = fail_q;
    assign fail_mask_o  = mask_q;

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push_en_s) begin
            mem_q[wr_ptr_q] <= push_param_i;
        end
    end

    // Next-state logic for the sequencer, queue pointers and status outputs.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        param_d   = param_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        mask_d    = mask_q;
        timer_d   = timer_q;

        if (push_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if ((state_q != S_IDLE) && abort_i) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end

        case (state_q)
            S_IDLE: begin
                // Clear beats run; a word pushed in the clearing cycle survives the flush.
                if (clear_i) begin
                    rd_ptr_d  = wr_ptr_q;
                    count_d   = push_en_s ? CW'(1) : CW'(0);
                    pass_d    = 8'd0;
                    fail_d    = 8'd0;
                    mask_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    abort_d   = 1'b0;
                end else if (run_i && (count_q != CW'(0))) begin
                    state_d   = S_ISSUE;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    pass_d    = 8'd0;
                    fail_d    = 8'd0;
                    mask_d    = '0;
                    idx_d     = '0;
                    abort_d   = 1'b0;
                    param_d   = mem_q[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (test_finished_i) begin
                    state_d = S_RECORD;
                end else if (timer_q == T_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RECORD: begin
                if (test_result_i) begin
                    fail_d        = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
                    mask_d[idx_q] = 1'b1;
                end else begin
                    pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
                end
                rd_ptr_d = rd_next_s;
                count_d  = count_q - CW'(1);
                if ((count_q == CW'(1)) || abort_q || abort_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    param_d = mem_q[rd_next_s];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            param_q   <= 32'd0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
            idx_q     <= '0;
            pass_q    <= 8'd0;
            fail_q    <= 8'd0;
            mask_q    <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            param_q   <= param_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
        end
    end
endmodule

// File: tb/tb_test_scheduler.sv
// Self-checking bench for test_scheduler: table of batches plus hand-written corner sequences,
// with a control-block model and a scoreboard of expected test parameters.
module tb_test_scheduler;
    logic        rst_i, clk_i;
    logic        push_valid_i, push_ready_o;
    logic [31:0] push_param_i;
    logic        clear_i, run_i, abort_i;
    logic        test_start_o;
    logic [31:0] test_param_o;
    logic        test_finished_i, test_result_i;
    logic        busy_o, done_o, timeout_o;
    logic [1:0]  test_idx_o;
    logic [7:0]  pass_cnt_o, fail_cnt_o;
    logic [3:0]  fail_mask_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic        res_q[$];
    int          mdl_lat = 3;
    bit          mdl_hang = 1'b0;

    typedef struct {
        int         n;
        int         lat;
        logic [3:0] res;
        logic [7:0] ep;
        logic [7:0] ef;
        logic [3:0] em;
    } vec_t;
    vec_t vecs[5];

    test_scheduler #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .rst_i(rst_i), .clk_i(clk_i),
        .push_valid_i(push_valid_i), .push_param_i(push_param_i), .push_ready_o(push_ready_o),
        .clear_i(clear_i), .run_i(run_i), .abort_i(abort_i),
        .test_start_o(test_start_o), .test_param_o(test_param_o),
        .test_finished_i(test_finished_i), .test_result_i(test_result_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .test_idx_o(test_idx_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .fail_mask_o(fail_mask_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Control block model: finished drops two cycles after start is seen, rises after mdl_lat.
    initial begin
        logic r;
        test_finished_i = 1'b0;
        test_result_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (test_start_o && !rst_i) begin
                obs_q.push_back(test_param_o);
                r = (res_q.size() > 0) ? res_q.pop_front() : 1'b0;
                @(negedge clk_i);
                @(negedge clk_i);
                test_finished_i = 1'b0;
                if (!mdl_hang) begin
                    repeat (mdl_lat) @(negedge clk_i);
                    test_finished_i = 1'b1;
                    test_result_i   = r;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        push_valid_i = 1'b1;
        push_param_i = w;
        if (push_ready_o) exp_q.push_back(w);
        @(negedge clk_i);
        push_valid_i = 1'b0;
    endtask

    task automatic run_pulse();
        run_i = 1'b1;
        @(negedge clk_i);
        run_i = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy_o && c < 400) begin
            @(negedge clk_i);
            c++;
        end
        check("batch_ends", 32'(busy_o), 32'd0);
    endtask

    task automatic compare_sb(input int n);
        check("start_count", 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            check("test_param", obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        check({tag, "_start"}, 32'(test_start_o), 32'd0);
        check({tag, "_param"}, test_param_o, 32'd0);
        check({tag, "_idx"}, 32'(test_idx_o), 32'd0);
        check({tag, "_pass"}, 32'(pass_cnt_o), 32'd0);
        check({tag, "_fail"}, 32'(fail_cnt_o), 32'd0);
        check({tag, "_mask"}, 32'(fail_mask_o), 32'd0);
        check({tag, "_ready"}, 32'(push_ready_o), 32'd1);
    endtask

    initial begin
        int k;
        vecs[0] = '{n: 3, lat: 2, res: 4'b0010, ep: 8'd2, ef: 8'd1, em: 4'b0010};
        vecs[1] = '{n: 4, lat: 1, res: 4'b1111, ep: 8'd0, ef: 8'd4, em: 4'b1111};
        vecs[2] = '{n: 1, lat: 5, res: 4'b0000, ep: 8'd1, ef: 8'd0, em: 4'b0000};
        vecs[3] = '{n: 4, lat: 3, res: 4'b1001, ep: 8'd2, ef: 8'd2, em: 4'b1001};
        vecs[4] = '{n: 2, lat: 7, res: 4'b0010, ep: 8'd1, ef: 8'd1, em: 4'b0010};

        rst_i = 1'b1; push_valid_i = 1'b0; push_param_i = 32'd0;
        clear_i = 1'b0; run_i = 1'b0; abort_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_zero_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int v = 0; v < 5; v++) begin
            mdl_lat = vecs[v].lat;
            for (int i = 0; i < vecs[v].n; i++) begin
                res_q.push_back(vecs[v].res[i]);
                push_word($urandom());
            end
            run_pulse();
            wait_idle();
            compare_sb(vecs[v].n);
            check("vec_pass", 32'(pass_cnt_o), 32'(vecs[v].ep));
            check("vec_fail", 32'(fail_cnt_o), 32'(vecs[v].ef));
            check("vec_mask", 32'(fail_mask_o), 32'(vecs[v].em));
            check("vec_done", 32'(done_o), 32'd1);
            check("vec_timeout", 32'(timeout_o), 32'd0);
            check("vec_idx", 32'(test_idx_o), 32'(vecs[v].n - 1));
            check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // Full queue: fifth word refused, batch issues words 1..4 in order.
        mdl_lat = 2;
        for (int i = 0; i < 4; i++) begin
            res_q.push_back(1'b0);
            push_word(32'h1000_0000 + 32'(i));
        end
        check("full_ready", 32'(push_ready_o), 32'd0);
        push_word(32'hDEAD_BEEF);
        run_pulse();
        wait_idle();
        compare_sb(4);
        check("full_pass", 32'(pass_cnt_o), 32'd4);
        check("full_sb_empty", 32'(exp_q.size()), 32'd0);

        // Abort during WAIT of test 0 of 3.
        mdl_lat = 10;
        for (int i = 0; i < 3; i++) begin
            res_q.push_back(1'b0);
            push_word(32'h2000_0000 + 32'(i));
        end
        run_pulse();
        repeat (4) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        wait_idle();
        compare_sb(1);
        check("abort_pass", 32'(pass_cnt_o), 32'd1);
        check("abort_done", 32'(done_o), 32'd1);
        check("abort_left", 32'(exp_q.size()), 32'd2);
        mdl_lat = 2;
        run_pulse();
        wait_idle();
        compare_sb(2);
        check("rerun_pass", 32'(pass_cnt_o), 32'd2);
        check("rerun_done", 32'(done_o), 32'd1);

        // Run with an empty queue changes nothing.
        run_pulse();
        repeat (5) @(negedge clk_i);
        check("empty_run_starts", 32'(obs_q.size()), 32'd0);
        check("empty_run_done", 32'(done_o), 32'd1);
        check("empty_run_pass", 32'(pass_cnt_o), 32'd2);
        check("empty_run_busy", 32'(busy_o), 32'd0);

        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clear_done", 32'(done_o), 32'd0);
        check("clear_pass", 32'(pass_cnt_o), 32'd0);
        check("clear_idx", 32'(test_idx_o), 32'd0);

        // Timeout after 16 WAIT cycles; entry retained and reissued on the next run.
        mdl_hang = 1'b1;
        res_q.push_back(1'b0);
        push_word(32'h3000_00AA);
        run_pulse();
        k = 0;
        while (busy_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'd18);
        check("timeout_flag", 32'(timeout_o), 32'd1);
        check("timeout_done", 32'(done_o), 32'd0);
        check("timeout_pass", 32'(pass_cnt_o), 32'd0);
        check("timeout_fail", 32'(fail_cnt_o), 32'd0);
        check("timeout_starts", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0 && exp_q.size() > 0) check("timeout_param", obs_q[0], exp_q[0]);
        obs_q.delete();
        mdl_hang = 1'b0;
        res_q.push_back(1'b0);
        run_pulse();
        wait_idle();
        compare_sb(1);
        check("retained_pass", 32'(pass_cnt_o), 32'd1);
        check("retained_timeout", 32'(timeout_o), 32'd0);

        // Reset mid-WAIT.
        mdl_lat = 10;
        push_word(32'h4000_0001);
        push_word(32'h4000_0002);
        run_pulse();
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_zero_outputs("midrst");
        rst_i = 1'b0;
        exp_q.delete();
        obs_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk_i);
        check("midrst_no_start", 32'(obs_q.size()), 32'd0);
        run_pulse();
        repeat (5) @(negedge clk_i);
        check("midrst_queue_empty", 32'(obs_q.size()), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/test_scheduler.md
TEST_SCHEDULER -- requirements
Module: test_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, queue depth in test-parameter words; power of 2, 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 1000000, maximum cycles to wait for one test to finish.
REQ-003 rst_i  in  1  asynchronous active-high reset.
REQ-004 clk_i  in  1  single clock; all logic is on the rising edge.
REQ-005 push_valid_i  in  1  CSR offers a test-parameter word.
REQ-006 push_param_i  in  32  test-parameter word: [31:16] count, [15:14] mode.
REQ-007 push_ready_o  out  1  queue accepts the word this cycle.
REQ-008 clear_i  in  1  flush queue and status; honoured only in IDLE.
REQ-009 run_i  in  1  start executing the queued batch.
REQ-010 abort_i  in  1  stop the batch after the current test.
REQ-011 test_start_o  out  1  one-cycle start pulse to the control block.
REQ-012 test_param_o  out  32  parameter word of the current test; stable while busy.
REQ-013 test_finished_i  in  1  control block finished flag (level).
REQ-014 test_result_i  in  1  control block result, 1 = error.
REQ-015 busy_o  out  1  batch in progress.
REQ-016 done_o  out  1  batch completed or aborted (level).
REQ-017 timeout_o  out  1  current test exceeded TIMEOUT_CYC.
REQ-018 test_idx_o  out  clog2(DEPTH)  index of the current test within the batch.
REQ-019 pass_cnt_o, fail_cnt_o  out  8 each  tests passed/failed in the batch; saturate at 255.
REQ-020 fail_mask_o  out  DEPTH  bit i set = batch test i failed.

Function
REQ-021 Queue: FIFO of up to DEPTH words; push_ready_o = (state==IDLE) && (count<DEPTH); a word is written when push_valid_i && push_ready_o.
REQ-022 FSM states: IDLE, ISSUE, ARM, WAIT, RECORD.
REQ-023 IDLE->ISSUE when run_i=1 and count before the edge is nonzero; run_i with an empty queue is ignored, with no status change.
REQ-024 Run accept: clear pass_cnt_o, fail_cnt_o, fail_mask_o, done_o, timeout_o and test_idx_o; set busy_o; load test_param_o from the queue head.
REQ-025 Same-cycle push and accepted run: both take effect; the pushed word joins the batch.
REQ-026 ISSUE: test_start_o=1 for exactly one cycle, then ARM.
REQ-027 ARM: one cycle in which test_finished_i is ignored, because the control block clears it one cycle after start; then WAIT.
REQ-028 WAIT: on test_finished_i=1, go to RECORD; the timeout counter resets on entry to WAIT and increments each WAIT cycle.
REQ-029 RECORD (1 cycle): if test_result_i=1, increment fail_cnt_o and set fail_mask_o[test_idx_o]; otherwise increment pass_cnt_o.
REQ-030 RECORD also pops the head.
REQ-031 After RECORD, if the queue is now empty or the abort flag is set: go to IDLE, busy_o=0, done_o=1.
REQ-032 After RECORD, in all other cases: increment test_idx_o, load test_param_o from the new head, go to ISSUE.
REQ-033 Abort: abort_i in any non-IDLE state sets a sticky flag, which is cleared on the next run accept; the current test completes and is recorded; abort_i in IDLE is ignored.
REQ-034 Timeout: if the counter reaches TIMEOUT_CYC-1 in WAIT without finish, then timeout_o=1, busy_o=0, done_o stays 0, state=IDLE.
REQ-035 On timeout, the current entry is not popped and the counters are unchanged.
REQ-036 Finish and timeout in the same cycle: finish wins.
REQ-037 clear_i in IDLE empties the queue and clears all status outputs; clear_i when not in IDLE is ignored.
REQ-038 No pushes occur outside IDLE, so push and pop never coincide.

Reset
REQ-039 Asynchronous reset sets state=IDLE, queue empty, test_start_o=0, test_param_o=0.
REQ-040 Asynchronous reset sets busy_o=0, done_o=0, timeout_o=0, test_idx_o=0.
REQ-041 Asynchronous reset sets pass_cnt_o=0, fail_cnt_o=0, fail_mask_o=0.
REQ-042 Reset mid-batch discards all queued entries and status; no start pulse is emitted on release.

Verification
REQ-043 Push 3 words, run; control block model returns results 0,1,0 -> three start pulses, pass_cnt=2, fail_cnt=1, fail_mask=4'b0010, done_o=1, queue empty.
REQ-044 Push 4 words (queue full), push a 5th -> push_ready_o=0 and the 5th word is not stored; run -> test_param_o sequence equals words 1..4.
REQ-045 Model holds test_finished_i=1 from the previous test and drops it one cycle after start -> no early RECORD; each test is recorded exactly once.
REQ-046 Abort during WAIT of test 0 of 3 -> test 0 recorded, no further start pulse, done_o=1, 2 entries remain queued.
REQ-047 TIMEOUT_CYC=16, model never finishes -> timeout_o=1 after 16 WAIT cycles, busy_o=0, done_o=0, entry retained.
REQ-048 Run with empty queue -> no start pulse, no status change; assert reset mid-WAIT -> all outputs 0, queue empty.
